// File: rtl/uart_frame_packer_pkg.sv
// Shared definitions for the UART frame packer.
// Holds the default sync byte, the frame length, the writer FSM state
// encoding and a helper that picks the byte a writer state emits.
package uart_frame_packer_pkg;

    localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
    localparam int unsigned FRAME_LEN         = 4;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StWSync = 3'd1,
        StWSeq  = 3'd2,
        StWHi   = 3'd3,
        StWLo   = 3'd4
    } wr_state_e;

    // Byte pushed into the FIFO while the writer sits in state st.
    function automatic logic [7:0] frame_byte(input wr_state_e   st,
                                              input logic [7:0]  sync,
                                              input logic [7:0]  seq,
                                              input logic [15:0] smp);
        case (st)
            StWSync: return sync;
            StWSeq:  return seq;
            StWHi:   return smp[15:8];
            StWLo:   return smp[7:0];
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/uart_frame_packer_byte_fifo.sv
// Byte FIFO, DEPTH x 8, with a registered read port (BRAM-friendly).
// The level counts every stored byte, including the one at the read pointer.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_data at the write pointer
//   push_data    byte to store
//   pop          discard the byte at the read pointer
//   rd_en        load rd_data from the byte at the read pointer
//   rd_data      registered read data
//   level        bytes stored, 0..DEPTH
module uart_frame_packer_byte_fifo #(
    parameter int unsigned  DEPTH  = 64,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [7:0]      push_data,
    input  logic            pop,
    input  logic            rd_en,
    output logic [7:0]      rd_data,
    output logic [ADDR_W:0] level
);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [ADDR_W:0]   level_q;

    // Storage has no reset so it can map onto block RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data <= 8'h00;
        end else if (rd_en) begin
            rd_data <= mem[rd_ptr_q];
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

    assign level = level_q;

endmodule

// File: rtl/uart_frame_packer.sv
// Packs 16-bit samples into 4-byte frames {SYNC, SEQ, MSB, LSB}, buffers
// them in a byte FIFO and presents the head byte to a UART transmitter
// with first-word-fall-through behaviour. Samples arriving while a frame
// is being written, or when fewer than 4 bytes are free, are dropped and
// counted.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   sample       sample word, valid with sample_stb
//   sample_stb   1-cycle new-sample strobe
//   tx_byte      head byte to the transmitter
//   tx_en        head byte valid
//   tx_stb       1-cycle pulse from the transmitter: head consumed
//   fifo_level   bytes stored, 0..DEPTH
//   drop_cnt     dropped samples, saturating at 255
//   busy         writer is emitting a frame
module uart_frame_packer
    import uart_frame_packer_pkg::*;
#(
    parameter int unsigned  DEPTH     = 64,
    parameter logic [7:0]   SYNC_BYTE = SYNC_BYTE_DEFAULT,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     sample,
    input  logic            sample_stb,
    output logic [7:0]      tx_byte,
    output logic            tx_en,
    input  logic            tx_stb,
    output logic [ADDR_W:0] fifo_level,
    output logic [7:0]      drop_cnt,
    output logic            busy
);

    // A frame fits when level <= DEPTH - FRAME_LEN.
    localparam logic [ADDR_W:0] LEVEL_MAX = (ADDR_W + 1)'(DEPTH - FRAME_LEN);

    wr_state_e       state_q;
    logic [15:0]     sample_q;
    logic [7:0]      seq_q;
    logic [7:0]      drop_cnt_q;
    logic            busy_q;
    logic            tx_en_q;

    logic            room;
    logic            accept;
    logic            drop;
    logic            push;
    logic [7:0]      push_data;
    logic            pop;
    logic            fetch;
    logic [ADDR_W:0] level;

    // Pops during a frame only free space, so checking room at accept time
    // guarantees the whole frame fits.
    assign room      = (level <= LEVEL_MAX);
    assign accept    = sample_stb && (state_q == StIdle) && room;
    assign drop      = sample_stb && !accept;
    assign push      = (state_q != StIdle);
    assign push_data = frame_byte(state_q, SYNC_BYTE, seq_q, sample_q);

    // Writer FSM with seq and drop counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            sample_q   <= 16'h0000;
            seq_q      <= 8'h00;
            drop_cnt_q <= 8'h00;
            busy_q     <= 1'b0;
        end else begin
            if (drop && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        sample_q <= sample;
                        state_q  <= StWSync;
                        busy_q   <= 1'b1;
                    end
                end
                StWSync: state_q <= StWSeq;
                StWSeq:  state_q <= StWHi;
                StWHi:   state_q <= StWLo;
                StWLo: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                    seq_q   <= seq_q + 8'd1;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // FWFT read side: tx_en marks that the registered read data holds the
    // head. A pop invalidates it; the next cycle refetches the new head if
    // any bytes remain, so the new head is visible two cycles after tx_stb.
    assign pop   = tx_en_q && tx_stb;
    assign fetch = !tx_en_q && (level != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_en_q <= 1'b0;
        end else if (pop) begin
            tx_en_q <= 1'b0;
        end else if (fetch) begin
            tx_en_q <= 1'b1;
        end
    end

    uart_frame_packer_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .rd_en     (fetch),
        .rd_data   (tx_byte),
        .level     (level)
    );

    assign tx_en      = tx_en_q;
    assign fifo_level = level;
    assign drop_cnt   = drop_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_uart_frame_packer.sv
module tb_uart_frame_packer;

    localparam int DEPTH = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] sample = 16'h0000;
    logic        sample_stb = 1'b0;
    logic [7:0]  tx_byte;
    logic        tx_en;
    logic        tx_stb = 1'b0;
    logic [6:0]  fifo_level;
    logic [7:0]  drop_cnt;
    logic        busy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    uart_frame_packer #(
        .DEPTH     (DEPTH),
        .SYNC_BYTE (8'hA5)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample     (sample),
        .sample_stb (sample_stb),
        .tx_byte    (tx_byte),
        .tx_en      (tx_en),
        .tx_stb     (tx_stb),
        .fifo_level (fifo_level),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    typedef struct {
        logic [15:0] smp;
        logic [31:0] frame;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        sample_stb = 1'b0;
        tx_stb = 1'b0;
        rst_n = 1'b0;
        cyc(2);
        rst_n = 1'b1;
        cyc(1);
    endtask

    task automatic pulse_sample(input logic [15:0] s);
        sample = s;
        sample_stb = 1'b1;
        @(negedge clk);
        sample_stb = 1'b0;
    endtask

    // Wait (bounded) for tx_en, check the head, consume it, then respect
    // the minimum transmitter bit period.
    task automatic pop_byte(input string name, input logic [7:0] exp);
        int waited = 0;
        while (!tx_en && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!tx_en) begin
            total++;
            bad++;
            $display("FAIL %s: tx_en got 0 expected 1", name);
        end else begin
            check(name, 32'(tx_byte), 32'(exp));
            tx_stb = 1'b1;
            @(negedge clk);
            tx_stb = 1'b0;
            cyc(3);
        end
    endtask

    task automatic pop_frame(input string name, input logic [31:0] frame);
        logic [31:0] f;
        f = frame;
        for (int k = 0; k < 4; k++) begin
            pop_byte($sformatf("%s_b%0d", name, k), f[31-8*k -: 8]);
        end
    endtask

    vec_t vecs[5];

    // Reference model state for the random run.
    logic [7:0] stored[$];
    logic [7:0] to_write[$];
    int         drops_m;
    logic [7:0] seq_m;
    int         gap;
    int         wait_en;
    int         pops;
    logic [15:0] s_r;
    logic        stb_r;
    logic        tstb_r;
    logic        acc;

    initial begin
        vecs[0] = '{smp: 16'hBEEF, frame: 32'hA501BEEF};
        vecs[1] = '{smp: 16'h0000, frame: 32'hA5020000};
        vecs[2] = '{smp: 16'hFFFF, frame: 32'hA503FFFF};
        vecs[3] = '{smp: 16'h00FF, frame: 32'hA50400FF};
        vecs[4] = '{smp: 16'h8001, frame: 32'hA5058001};

        // Reset state while held in reset.
        cyc(1);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'd0);
        check("rst_level", 32'(fifo_level), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        cyc(1);

        // 1: single frame lands after 5 cycles.
        pulse_sample(16'h1234);
        check("t1_busy", 32'(busy), 32'd1);
        cyc(3);
        check("t1_level3", 32'(fifo_level), 32'd3);
        cyc(1);
        check("t1_level4", 32'(fifo_level), 32'd4);
        check("t1_tx_en", 32'(tx_en), 32'd1);
        check("t1_busy_done", 32'(busy), 32'd0);
        check("t1_drop", 32'(drop_cnt), 32'd0);

        // 2: drain the frame.
        pop_frame("t2", 32'hA5001234);
        check("t2_tx_en", 32'(tx_en), 32'd0);
        check("t2_level", 32'(fifo_level), 32'd0);

        // Table of sample -> frame, seq continuing from 01.
        for (int i = 0; i < 5; i++) begin
            pulse_sample(vecs[i].smp);
            pop_frame($sformatf("vec%0d", i), vecs[i].frame);
        end

        // 3: 257 frames, seq wraps.
        do_reset();
        for (int i = 0; i < 257; i++) begin
            logic [7:0] ex;
            ex = 8'(i);
            pulse_sample(16'(i * 37));
            pop_byte($sformatf("t3_sync%0d", i), 8'hA5);
            pop_byte($sformatf("t3_seq%0d", i), ex);
            pop_byte($sformatf("t3_hi%0d", i), 8'(16'(i * 37) >> 8));
            pop_byte($sformatf("t3_lo%0d", i), 8'(i * 37));
        end
        check("t3_drop", 32'(drop_cnt), 32'd0);

        // 4: fill the FIFO with no consumer.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            pulse_sample(16'(i));
            cyc(4);
        end
        check("t4_level_full", 32'(fifo_level), 32'd64);
        check("t4_drop1", 32'(drop_cnt), 32'd1);
        pop_byte("t4_head", 8'hA5);
        check("t4_level63", 32'(fifo_level), 32'd63);
        pulse_sample(16'h7777);
        cyc(4);
        check("t4_drop2", 32'(drop_cnt), 32'd2);
        check("t4_level_still63", 32'(fifo_level), 32'd63);
        check("t4_busy", 32'(busy), 32'd0);

        // 5: strobe during a frame, then saturation.
        do_reset();
        pulse_sample(16'h1111);
        cyc(1);
        pulse_sample(16'h2222);
        check("t5_drop1", 32'(drop_cnt), 32'd1);
        cyc(4);
        check("t5_level", 32'(fifo_level), 32'd4);
        sample_stb = 1'b1;
        cyc(300);
        sample_stb = 1'b0;
        cyc(1);
        check("t5_sat", 32'(drop_cnt), 32'd255);
        pulse_sample(16'h3333);
        check("t5_sat_hold", 32'(drop_cnt), 32'd255);

        // 6: reset in W_HI.
        do_reset();
        pulse_sample(16'hCAFE);
        cyc(2);
        rst_n = 1'b0;
        #1;
        check("t6_level", 32'(fifo_level), 32'd0);
        check("t6_tx_en", 32'(tx_en), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(5);
        check("t6_level_after", 32'(fifo_level), 32'd0);
        check("t6_tx_en_after", 32'(tx_en), 32'd0);
        pulse_sample(16'h5A5A);
        pop_frame("t6", 32'hA5005A5A);

        // Random run against the queue model.
        do_reset();
        drops_m = 0;
        seq_m = 8'h00;
        gap = 10;
        wait_en = 0;
        pops = 0;
        for (int c = 0; c < 6000; c++) begin
            check("rnd_level", 32'(fifo_level), 32'(stored.size()));
            check("rnd_busy", 32'(busy), 32'(to_write.size() != 0));
            check("rnd_drop", 32'(drop_cnt), 32'(drops_m));
            if (tx_en) begin
                if (stored.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL rnd_tx_en: got 1 expected 0 (model empty)");
                end else begin
                    check("rnd_tx_byte", 32'(tx_byte), 32'(stored[0]));
                end
                wait_en = 0;
            end else if (stored.size() != 0) begin
                wait_en++;
                if (wait_en > 2) begin
                    total++;
                    bad++;
                    $display("FAIL rnd_head_latency: got %0d cycles expected <=2", wait_en);
                    wait_en = 0;
                end
            end

            stb_r = ($urandom_range(0, 5) == 0);
            s_r = 16'($urandom);
            if (c < 3000) tstb_r = tx_en && (gap >= 3) && ($urandom_range(0, 15) == 0);
            else tstb_r = tx_en && (gap >= 3) && ($urandom_range(0, 1) == 0);
            gap = tstb_r ? 0 : gap + 1;
            sample = s_r;
            sample_stb = stb_r;
            tx_stb = tstb_r;

            acc = stb_r && (to_write.size() == 0) && (stored.size() <= DEPTH - 4);
            if (stb_r && !acc && drops_m < 255) drops_m++;
            if (tstb_r && stored.size() != 0) begin
                void'(stored.pop_front());
                pops++;
            end
            if (to_write.size() != 0) stored.push_back(to_write.pop_front());
            if (acc) begin
                to_write.push_back(8'hA5);
                to_write.push_back(seq_m);
                to_write.push_back(s_r[15:8]);
                to_write.push_back(s_r[7:0]);
                seq_m = seq_m + 8'd1;
            end
            @(negedge clk);
        end
        sample_stb = 1'b0;
        tx_stb = 1'b0;
        check("rnd_consumed_some", 32'(pops > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
